// File: rtl/st_dma_ctrl.sv
// Host-side DMA controller for the ST floppy/HDC DMA port: register window, device chip-select
// cycles, word acknowledges and 8-word memory bursts. Option macro: DMA_FIFO_LEVEL_EN (status[7:4] = FIFO level).
module st_dma_ctrl #(
  parameter int unsigned FCS_CYCLES   = 4,
  parameter int unsigned ACK_CYCLES   = 2,
  parameter int unsigned SECTOR_WORDS = 256
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        cpu_sel,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_a,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        FCS_N,
  output logic        RW,
  output logic        A1,
  input  logic        RDY_I,
  output logic        RDY_O,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned LW    = 4;
  localparam int unsigned TW    = 8;
  localparam int unsigned AW    = 23;
  localparam int unsigned WCW   = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FCS, ACK, ACK_GAP, BURST, FILL} state_t;

  state_t          state, state_nxt;
  logic            dir, dma_dis, sc_sel, hdc_sel, a1_sel;
  logic [7:0]      sec_cnt;
  logic            err;
  logic [15:0]     fifo [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, beat;
  logic [LW-1:0]   level;
  logic [WCW-1:0]  word_cnt;
  logic [TW-1:0]   tick;

  logic            cpu_go, is_data, reg_go, cnt_go, fcs_go, reg_wr;
  logic            xfer_en, ack_ok, fcs_done, ack_done, mem_busy, mem_last;
  logic            ack_start, push, pop, flush, sector_end;
  logic [15:0]     push_data, status, reg_rdata;

  // Request decode: $8604 is only taken from IDLE, everything else is answered at once
  assign cpu_go     = cpu_sel && !cpu_ack;
  assign is_data    = (cpu_a == 3'd2);
  assign reg_go     = cpu_go && !is_data;
  assign cnt_go     = cpu_go && is_data && sc_sel && (state == IDLE);
  assign fcs_go     = cpu_go && is_data && !sc_sel && (state == IDLE);
  assign reg_wr     = reg_go && !cpu_rw;
  assign flush      = reg_wr && (cpu_a == 3'd3) && (cpu_din[8] != dir);

  assign xfer_en    = !dma_dis && (sec_cnt != 8'd0);
  assign ack_ok     = xfer_en && RDY_I && (dir ? (level != '0) : (level != LW'(DEPTH)));
  assign fcs_done   = (state == FCS) && clk_en && (tick == TW'(FCS_CYCLES - 1));
  assign ack_done   = (state == ACK) && clk_en && (tick == TW'(ACK_CYCLES - 1));
  assign mem_busy   = (state == BURST) || (state == FILL);
  assign mem_last   = mem_busy && mem_ack && (beat == PW'(DEPTH - 1));
  assign sector_end = (word_cnt == WCW'(SECTOR_WORDS - 1));

  assign push       = (ack_start && !dir) || ((state == FILL) && mem_ack);
  assign pop        = (ack_start && dir) || ((state == BURST) && mem_ack);
  assign push_data  = dir ? mem_rdata : DIN;

  always_ff @(posedge clk32) begin
    if (!resb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Arbitration from IDLE: CPU device access, then memory burst/fill, then word acknowledge
  always_comb begin
    state_nxt = state;
    ack_start = 1'b0;
    case (state)
      IDLE: begin
        if (fcs_go)                                  state_nxt = FCS;
        else if (!dir && (level == LW'(DEPTH)))      state_nxt = BURST;
        else if (dir && (level == '0) && xfer_en)    state_nxt = FILL;
        else if (ack_ok) begin
          state_nxt = ACK;
          ack_start = 1'b1;
        end
      end
      FCS:         if (fcs_done) state_nxt = IDLE;
      ACK:         if (ack_done) state_nxt = ACK_GAP;
      ACK_GAP:     if (clk_en)   state_nxt = IDLE;
      BURST, FILL: if (mem_last) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Register read mux; index 1 reads back the stored mode bits
  always_comb begin
    status    = 16'd0;
    status[0] = err;
    status[1] = (sec_cnt != 8'd0);
    status[2] = RDY_I;
`ifdef DMA_FIFO_LEVEL_EN
    status[7:4] = level;
`endif
    reg_rdata = 16'd0;
    case (cpu_a)
      3'd1:    reg_rdata = {7'd0, dir, 1'b0, dma_dis, 1'b0, sc_sel, hdc_sel, 1'b0, a1_sel, 1'b0};
      3'd3:    reg_rdata = status;
      3'd4:    reg_rdata = {8'd0, mem_addr[22:15]};
      3'd5:    reg_rdata = {8'd0, mem_addr[14:7]};
      3'd6:    reg_rdata = {8'd0, mem_addr[6:0], 1'b0};
      default: reg_rdata = 16'd0;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (push) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      dir       <= 1'b0;
      dma_dis   <= 1'b0;
      sc_sel    <= 1'b0;
      hdc_sel   <= 1'b0;
      a1_sel    <= 1'b0;
      sec_cnt   <= 8'd0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      beat      <= '0;
      word_cnt  <= '0;
      tick      <= '0;
      cpu_dout  <= 16'd0;
      cpu_ack   <= 1'b0;
      FCS_N     <= 1'b1;
      RW        <= 1'b1;
      A1        <= 1'b0;
      RDY_O     <= 1'b0;
      DOUT      <= 16'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'd0;
    end else begin
      cpu_ack <= 1'b0;
      if (state_nxt != state) tick <= '0;
      else if (clk_en)        tick <= tick + TW'(1);

      if (state_nxt != state)       beat <= '0;
      else if (mem_busy && mem_ack) beat <= beat + PW'(1);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end

      if (flush)          word_cnt <= '0;
      else if (ack_start) word_cnt <= sector_end ? '0 : word_cnt + WCW'(1);

      if (cnt_go && !cpu_rw)
        sec_cnt <= cpu_din[7:0];
      else if (ack_start && sector_end && (sec_cnt != 8'd0))
        sec_cnt <= sec_cnt - 8'd1;

      if (flush)                                         err <= 1'b0;
      else if (RDY_I && !dma_dis && (sec_cnt == 8'd0))   err <= 1'b1;

      if (reg_wr && (cpu_a == 3'd3)) begin
        dir     <= cpu_din[8];
        dma_dis <= cpu_din[6];
        sc_sel  <= cpu_din[4];
        hdc_sel <= cpu_din[3];
        a1_sel  <= cpu_din[1];
      end

      // CPU byte writes take priority over the running address increment
      if (mem_busy && mem_ack) mem_addr <= mem_addr + AW'(1);
      if (reg_wr) begin
        case (cpu_a)
          3'd4:    mem_addr[22:15] <= cpu_din[7:0];
          3'd5:    mem_addr[14:7]  <= cpu_din[7:0];
          3'd6:    mem_addr[6:0]   <= cpu_din[7:1];
          default: ;
        endcase
      end

      if (reg_go || cnt_go) begin
        cpu_ack <= 1'b1;
        if (cpu_rw) cpu_dout <= reg_rdata;
      end
      if (fcs_done) begin
        cpu_ack <= 1'b1;
        if (RW) cpu_dout <= DIN;
      end

      FCS_N <= (state_nxt != FCS);
      A1    <= a1_sel;
      RDY_O <= (state_nxt == ACK);
      if ((state == IDLE) && (state_nxt == FCS)) begin
        RW <= cpu_rw;
        if (!cpu_rw) DOUT <= cpu_din;
      end else if (state_nxt != FCS) begin
        RW <= 1'b1;
      end
      if (ack_start && dir) DOUT <= fifo[rd_ptr];

      mem_req <= (state_nxt == BURST) || (state_nxt == FILL);
      mem_we  <= (state_nxt == BURST);
      if (state_nxt == BURST) mem_wdata <= fifo[pop ? rd_ptr + PW'(1) : rd_ptr];
    end
  end

endmodule

// File: tb/tb_st_dma_ctrl.sv
// Directed self-checking bench for st_dma_ctrl: register window, FCS cycle, device-to-memory
// bursts, memory-to-device fills, sector-count error and reset during a burst.
module tb_st_dma_ctrl;

  logic        clk32, resb, clk_en;
  logic        cpu_sel, cpu_rw;
  logic [2:0]  cpu_a;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        FCS_N, RW, A1, RDY_I, RDY_O;
  logic [15:0] DIN, DOUT;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  st_dma_ctrl dut (
    .clk32(clk32), .resb(resb), .clk_en(clk_en),
    .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_a(cpu_a), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .FCS_N(FCS_N), .RW(RW), .A1(A1), .RDY_I(RDY_I), .RDY_O(RDY_O),
    .DIN(DIN), .DOUT(DOUT),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

`ifdef DMA_FIFO_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mem_model [0:255];
  logic [22:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          rd_count = 0;
  logic        mem_stall = 1'b0;

  int          fcs_low;
  logic        fcs_rw, fcs_a1;
  logic [15:0] fcs_dout;

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] st_exp(input int lvl, input logic [2:0] low);
    return (LVL_EN ? (32'(lvl) << 4) : 32'd0) | 32'(low);
  endfunction

  // Memory model: random one-cycle acks; logs writes and serves reads
  always @(negedge clk32) begin
    mem_ack = 1'b0;
    if (mem_req && !mem_stall && ($urandom_range(0, 2) != 0)) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        mem_rdata = mem_model[mem_addr[7:0]];
        rd_count++;
      end
    end
  end

  task automatic cpu_access(input logic rw, input logic [2:0] a, input logic [15:0] d,
                            output logic [15:0] rdata);
    int n;
    @(negedge clk32);
    cpu_sel = 1'b1; cpu_rw = rw; cpu_a = a; cpu_din = d;
    fcs_low = 0; fcs_rw = 1'b1; fcs_a1 = 1'b0; fcs_dout = 16'd0;
    n = 0;
    do begin
      @(negedge clk32);
      n++;
      if (!FCS_N) begin
        if (fcs_low == 0) begin
          fcs_rw = RW; fcs_a1 = A1; fcs_dout = DOUT;
        end
        fcs_low++;
      end
    end while (!cpu_ack && n < 300);
    if (!cpu_ack) check("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
    rdata = cpu_dout;
    cpu_sel = 1'b0;
  endtask

  task automatic dev_word(input logic [15:0] w, output logic [15:0] seen, output int hi,
                          output int rdc);
    int n;
    @(negedge clk32);
    DIN = w; RDY_I = 1'b1;
    n = 0;
    do begin
      @(negedge clk32);
      n++;
    end while (!RDY_O && n < 500);
    if (!RDY_O) check("rdy_o_timeout", 32'(RDY_O), 32'd1);
    seen = DOUT;
    rdc  = rd_count;
    RDY_I = 1'b0;
    hi = 0; n = 0;
    while (RDY_O && n < 50) begin
      hi++;
      @(negedge clk32);
      n++;
    end
  endtask

  initial begin
    logic [15:0] r, seen;
    int hi, rdc, cnt, n;

    resb = 1'b0; clk_en = 1'b1; cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_a = 3'd0; cpu_din = 16'd0;
    RDY_I = 1'b0; DIN = 16'd0; mem_ack = 1'b0; mem_rdata = 16'd0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'hA000 + 16'(i);

    // Reset state
    repeat (3) @(negedge clk32);
    check("rst_fcs_n", 32'(FCS_N), 32'd1);
    check("rst_rdy_o", 32'(RDY_O), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rw", 32'(RW), 32'd1);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    resb = 1'b1;
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("rst_status", 32'(r), st_exp(0, 3'b000));

    // Sector count and device FCS cycles
    cpu_access(1'b0, 3'd3, 16'h0090, r);
    cpu_access(1'b0, 3'd2, 16'h0001, r);
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("status_count1", 32'(r), st_exp(0, 3'b010));
    cpu_access(1'b0, 3'd3, 16'h0080, r);
    cpu_access(1'b0, 3'd2, 16'h0123, r);
    check("fcs_wr_len", 32'(fcs_low), 32'd4);
    check("fcs_wr_rw", 32'(fcs_rw), 32'd0);
    check("fcs_wr_a1", 32'(fcs_a1), 32'd0);
    check("fcs_wr_dout", 32'(fcs_dout), 32'h0123);
    DIN = 16'hBEEF;
    cpu_access(1'b0, 3'd3, 16'h0082, r);
    cpu_access(1'b1, 3'd2, 16'd0, r);
    check("fcs_rd_data", 32'(r), 32'hBEEF);
    check("fcs_rd_len", 32'(fcs_low), 32'd4);
    check("fcs_rd_rw", 32'(fcs_rw), 32'd1);
    check("fcs_rd_a1", 32'(fcs_a1), 32'd1);
    cpu_access(1'b0, 3'd3, 16'h0080, r);

    // Device -> memory: 16 words at byte 0x010000 (word 0x8000)
    cpu_access(1'b0, 3'd4, 16'h0001, r);
    cpu_access(1'b0, 3'd5, 16'h0000, r);
    cpu_access(1'b0, 3'd6, 16'h000F, r);
    cpu_access(1'b1, 3'd6, 16'd0, r);
    check("addr_lo_bit0", 32'(r), 32'h000E);
    cpu_access(1'b0, 3'd6, 16'h0000, r);
    for (int i = 0; i < 16; i++) begin
      dev_word(16'h0200 + 16'(i), seen, hi, rdc);
      if (i == 0) check("rdy_o_width", 32'(hi), 32'd2);
    end
    n = 0;
    while ((wr_addr_q.size() < 16 || mem_req) && n < 2000) begin
      @(negedge clk32);
      n++;
    end
    check("burst_words", 32'(wr_addr_q.size()), 32'd16);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      check($sformatf("burst_addr_%0d", i), 32'(wr_addr_q[i]), 32'h8000 + 32'(i));
      check($sformatf("burst_data_%0d", i), 32'(wr_data_q[i]), 32'h0200 + 32'(i));
    end
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("status_after_wr", 32'(r), st_exp(0, 3'b010));
    cpu_access(1'b1, 3'd6, 16'd0, r);
    check("addr_lo_after_wr", 32'(r), 32'h0020);

    // Memory -> device from word 0x8020
    cpu_access(1'b0, 3'd3, 16'h0140, r);
    cpu_access(1'b0, 3'd4, 16'h0001, r);
    cpu_access(1'b0, 3'd5, 16'h0000, r);
    cpu_access(1'b0, 3'd6, 16'h0040, r);
    rd_count = 0;
    cpu_access(1'b0, 3'd3, 16'h0100, r);
    for (int i = 0; i < 16; i++) begin
      dev_word(16'd0, seen, hi, rdc);
      if (i == 0) check("fill_before_ack", 32'(rdc), 32'd8);
      check($sformatf("dout_%0d", i), 32'(seen), 32'hA020 + 32'(i));
    end

    // Sector count zero: error, no acknowledge; direction toggle flushes
    repeat (4) @(negedge clk32);
    n = 0;
    while (mem_req && n < 500) begin
      @(negedge clk32);
      n++;
    end
    if (mem_req) check("fill_end_timeout", 32'(mem_req), 32'd0);
    cpu_access(1'b0, 3'd3, 16'h0110, r);
    cpu_access(1'b0, 3'd2, 16'h0000, r);
    cpu_access(1'b0, 3'd3, 16'h0100, r);
    @(negedge clk32);
    RDY_I = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk32);
      if (RDY_O) cnt++;
    end
    check("no_ack_count0", 32'(cnt), 32'd0);
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("status_err", 32'(r), st_exp(8, 3'b101));
    RDY_I = 1'b0;
    cpu_access(1'b0, 3'd3, 16'h0000, r);
    cnt = 0;
    repeat (10) begin
      @(negedge clk32);
      if (mem_req) cnt++;
    end
    check("flush_no_burst", 32'(cnt), 32'd0);
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("status_flushed", 32'(r), st_exp(0, 3'b000));

    // Reset in the middle of a stalled burst
    cpu_access(1'b0, 3'd3, 16'h0010, r);
    cpu_access(1'b0, 3'd2, 16'h0001, r);
    cpu_access(1'b0, 3'd3, 16'h0000, r);
    mem_stall = 1'b1;
    for (int i = 0; i < 8; i++) dev_word(16'h0300 + 16'(i), seen, hi, rdc);
    n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk32);
      n++;
    end
    check("burst_started", 32'(mem_req), 32'd1);
    resb = 1'b0;
    @(negedge clk32);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_fcs_n", 32'(FCS_N), 32'd1);
    check("mid_rst_rw", 32'(RW), 32'd1);
    check("mid_rst_a1", 32'(A1), 32'd0);
    check("mid_rst_rdy_o", 32'(RDY_O), 32'd0);
    check("mid_rst_dout", 32'(DOUT), 32'd0);
    check("mid_rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    resb = 1'b1;
    mem_stall = 1'b0;
    cpu_access(1'b1, 3'd3, 16'd0, r);
    check("post_rst_status", 32'(r), st_exp(0, 3'b000));
    repeat (5) @(negedge clk32);
    check("post_rst_idle", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
